// File: rtl/shift_seq_pkg.sv
// shift_pkg: encodings shared by the shift sequencer, its checking model and
// the downstream shifter.
//   - 3-bit shifter op codes (OP_*)
//   - 2-bit command op codes (CMD_*)
//   - sequencer state enum
//   - map_op(): command op -> shifter op
package shift_pkg;

   localparam int DW_DEF    = 8;
   localparam int REP_W_DEF = 4;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_LSL  = 3'b010;
   localparam logic [2:0] OP_LSR  = 3'b011;
   localparam logic [2:0] OP_ASR  = 3'b100;

   localparam logic [1:0] CMD_LSL = 2'b00;
   localparam logic [1:0] CMD_LSR = 2'b01;
   localparam logic [1:0] CMD_ASR = 2'b10;
   localparam logic [1:0] CMD_RSV = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SHIFT = 3'd2,
      S_CAPT  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   // Reserved command op never produces a shift; it maps to NOP.
   function automatic logic [2:0] map_op(input logic [1:0] cmd_op);
      logic [2:0] r;
      case (cmd_op)
         CMD_LSL: r = OP_LSL;
         CMD_LSR: r = OP_LSR;
         CMD_ASR: r = OP_ASR;
         default: r = OP_NOP;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/shift_seq_if.sv
// shift_seq_if: command and result handshakes of the shift sequencer.
//   cmd_*  : command channel (valid/ready), master -> slave
//   res_*  : result channel (valid/ready), slave -> master
// master = command source / result consumer, slave = sequencer.
interface shift_seq_if #(
   parameter int DW    = 8,
   parameter int REP_W = 4
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [1:0]       cmd_shamt;
   logic [REP_W-1:0] cmd_rep;
   logic [DW-1:0]    cmd_data;
   logic             res_valid;
   logic             res_ready;
   logic [DW-1:0]    res_data;
   logic             res_err;

   modport master (
      output cmd_valid, cmd_op, cmd_shamt, cmd_rep, cmd_data, res_ready,
      input  cmd_ready, res_valid, res_data, res_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_shamt, cmd_rep, cmd_data, res_ready,
      output cmd_ready, res_valid, res_data, res_err
   );
endinterface

// File: rtl/shift_seq_model.sv
// shift_seq_model: reference register tracking what the shifter should hold.
// Loaded on load, shifted by the command op on step (LSL/LSR zero-fill,
// ASR replicates the MSB).
// Ports: clk, reset_n (async active-low), load, step, op (command op),
//        shamt, d (load value), q (model value).
module shift_seq_model
   import shift_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load,
   input  logic          step,
   input  logic [1:0]    op,
   input  logic [1:0]    shamt,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);
   logic [DW-1:0] model_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         model_reg <= '0;
      end else if (load) begin
         model_reg <= d;
      end else if (step) begin
         case (op)
            CMD_LSL: model_reg <= model_reg << shamt;
            CMD_LSR: model_reg <= model_reg >> shamt;
            CMD_ASR: model_reg <= $unsigned($signed(model_reg) >>> shamt);
            default: model_reg <= model_reg;
         endcase
      end
   end

   assign q = model_reg;
endmodule

// File: rtl/shifter8.sv
// shifter8: registered shifter driven by shift_seq.
// Ports: clk, reset_n (async active-low), op (NOP/LOAD/LSL/LSR/ASR),
//        shamt (0..3), d_in (load value), d_out (registered result).
// The op applied in cycle k is visible on d_out in cycle k+1.
module shifter8
   import shift_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [2:0]    op,
   input  logic [1:0]    shamt,
   input  logic [DW-1:0] d_in,
   output logic [DW-1:0] d_out
);
   logic [DW-1:0] q_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_reg <= '0;
      end else begin
         case (op)
            OP_LOAD: q_reg <= d_in;
            OP_LSL:  q_reg <= q_reg << shamt;
            OP_LSR:  q_reg <= q_reg >> shamt;
            OP_ASR:  q_reg <= $unsigned($signed(q_reg) >>> shamt);
            default: q_reg <= q_reg;
         endcase
      end
   end

   assign d_out = q_reg;
endmodule

// File: rtl/shift_seq.sv
// shift_seq: command sequencer in front of shifter8.
// Accepts a command (op, shamt, rep, data), issues LOAD then rep shift steps
// to the shifter, captures the shifter output and returns it on the result
// handshake (with backpressure).
// Ports: clk, reset_n (async active-low), bus (shift_seq_if.slave: cmd_* and
//        res_*), sh_op/sh_shamt/sh_d_in (to shifter), sh_q (from shifter).
// Optional: SHIFT_SEQ_CHK_EN adds a reference register and drives res_err
// with the compare of sh_q against it; otherwise res_err is 0.
module shift_seq
   import shift_pkg::*;
#(
   parameter int DW    = 8,
   parameter int REP_W = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   shift_seq_if.slave    bus,
   output logic [2:0]    sh_op,
   output logic [1:0]    sh_shamt,
   output logic [DW-1:0] sh_d_in,
   input  logic [DW-1:0] sh_q
);
   state_t           state_reg,     state_next;
   logic [1:0]       op_reg,        op_next;
   logic [1:0]       shamt_reg,     shamt_next;
   logic [REP_W-1:0] cnt_reg,       cnt_next;
   logic             cmd_ready_reg, cmd_ready_next;
   logic [2:0]       sh_op_reg,     sh_op_next;
   logic [1:0]       sh_shamt_reg,  sh_shamt_next;
   logic [DW-1:0]    sh_d_in_reg,   sh_d_in_next;
   logic             res_valid_reg, res_valid_next;
   logic [DW-1:0]    res_data_reg,  res_data_next;

   // Outputs are registered, so next-state logic also computes the output
   // values that belong to the state being entered.
   always_comb begin
      state_next     = state_reg;
      op_next        = op_reg;
      shamt_next     = shamt_reg;
      cnt_next       = cnt_reg;
      cmd_ready_next = 1'b0;
      sh_op_next     = OP_NOP;
      sh_shamt_next  = sh_shamt_reg;
      sh_d_in_next   = sh_d_in_reg;
      res_valid_next = res_valid_reg;
      res_data_next  = res_data_reg;

      case (state_reg)
         S_IDLE: begin
            if (bus.cmd_valid && cmd_ready_reg) begin
               op_next      = bus.cmd_op;
               shamt_next   = bus.cmd_shamt;
               // Reserved op is forced to load-only.
               cnt_next     = (bus.cmd_op == CMD_RSV) ? '0 : bus.cmd_rep;
               sh_op_next   = OP_LOAD;
               sh_d_in_next = bus.cmd_data;
               state_next   = S_LOAD;
            end else begin
               cmd_ready_next = 1'b1;
            end
         end
         S_LOAD: begin
            if (cnt_reg != '0) begin
               sh_op_next    = map_op(op_reg);
               sh_shamt_next = shamt_reg;
               state_next    = S_SHIFT;
            end else begin
               state_next = S_CAPT;
            end
         end
         S_SHIFT: begin
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == REP_W'(1)) begin
               state_next = S_CAPT;
            end else begin
               sh_op_next    = map_op(op_reg);
               sh_shamt_next = shamt_reg;
            end
         end
         S_CAPT: begin
            res_data_next  = sh_q;
            res_valid_next = 1'b1;
            state_next     = S_RESP;
         end
         S_RESP: begin
            if (bus.res_ready) begin
               res_valid_next = 1'b0;
               cmd_ready_next = 1'b1;
               state_next     = S_IDLE;
            end
         end
         default: begin
            cmd_ready_next = 1'b1;
            state_next     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= S_IDLE;
         op_reg        <= '0;
         shamt_reg     <= '0;
         cnt_reg       <= '0;
         cmd_ready_reg <= 1'b1;
         sh_op_reg     <= OP_NOP;
         sh_shamt_reg  <= '0;
         sh_d_in_reg   <= '0;
         res_valid_reg <= 1'b0;
         res_data_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         op_reg        <= op_next;
         shamt_reg     <= shamt_next;
         cnt_reg       <= cnt_next;
         cmd_ready_reg <= cmd_ready_next;
         sh_op_reg     <= sh_op_next;
         sh_shamt_reg  <= sh_shamt_next;
         sh_d_in_reg   <= sh_d_in_next;
         res_valid_reg <= res_valid_next;
         res_data_reg  <= res_data_next;
      end
   end

`ifdef SHIFT_SEQ_CHK_EN
   logic [DW-1:0] model_q;
   logic          res_err_reg;

   // sh_d_in_reg holds the latched operand throughout the LOAD cycle.
   shift_seq_model #(.DW(DW)) u_model (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (state_reg == S_LOAD),
      .step    (state_reg == S_SHIFT),
      .op      (op_reg),
      .shamt   (shamt_reg),
      .d       (sh_d_in_reg),
      .q       (model_q)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res_err_reg <= 1'b0;
      end else if (state_reg == S_CAPT) begin
         res_err_reg <= (sh_q != model_q);
      end else if (state_reg == S_RESP && bus.res_ready) begin
         res_err_reg <= 1'b0;
      end
   end

   assign bus.res_err = res_err_reg;
`else
   assign bus.res_err = 1'b0;
`endif

   assign bus.cmd_ready = cmd_ready_reg;
   assign bus.res_valid = res_valid_reg;
   assign bus.res_data  = res_data_reg;
   assign sh_op         = sh_op_reg;
   assign sh_shamt      = sh_shamt_reg;
   assign sh_d_in       = sh_d_in_reg;
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: shift_seq driving shifter8, directed plus random commands
// checked against an arithmetic reference of the shift rules.
module tb_shift_seq;
   logic       clk;
   logic       reset_n;
   logic [2:0] sh_op;
   logic [1:0] sh_shamt;
   logic [7:0] sh_d_in;
   logic [7:0] sh_q;

   int n_checks;
   int n_fail;
   int n_load;
   int n_shift;
   int n_badop;
   logic [2:0] exp_sh_op;

   shift_seq_if #(.DW(8), .REP_W(4)) bus ();

   shift_seq #(.DW(8), .REP_W(4)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus.slave),
      .sh_op    (sh_op),
      .sh_shamt (sh_shamt),
      .sh_d_in  (sh_d_in),
      .sh_q     (sh_q)
   );

   shifter8 #(.DW(8)) u_shifter (
      .clk     (clk),
      .reset_n (reset_n),
      .op      (sh_op),
      .shamt   (sh_shamt),
      .d_in    (sh_d_in),
      .d_out   (sh_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running op monitor; the stimulus takes deltas around each command.
   initial begin
      n_load  = 0;
      n_shift = 0;
      n_badop = 0;
   end
   always @(negedge clk) begin
      if (reset_n) begin
         if (sh_op == 3'b001) n_load++;
         if (sh_op == 3'b010 || sh_op == 3'b011 || sh_op == 3'b100) begin
            n_shift++;
            if (sh_op != exp_sh_op) n_badop++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: apply the command's rule rep times with plain arithmetic.
   function automatic logic [7:0] ref_result(input logic [1:0] op, input logic [1:0] sh,
                                             input logic [3:0] rep, input logic [7:0] data);
      int v;
      v = data;
      if (op == 2'b11) return data;
      for (int i = 0; i < rep; i++) begin
         case (op)
            2'b00: v = (v * (2 ** sh)) % 256;
            2'b01: v = v / (2 ** sh);
            default: begin
               if (v >= 128) v = v - 256;
               v = v >>> sh;
               if (v < 0) v = v + 256;
            end
         endcase
      end
      return v[7:0];
   endfunction

   task automatic run_cmd(input logic [1:0] op, input logic [1:0] sh, input logic [3:0] rep,
                          input logic [7:0] data, input int hold);
      int lat;
      int eff;
      int load0, shift0, bad0;
      logic [7:0] exp;
      logic [7:0] held;
      exp = ref_result(op, sh, rep, data);
      eff = (op == 2'b11) ? 0 : int'(rep);
      case (op)
         2'b00:   exp_sh_op = 3'b010;
         2'b01:   exp_sh_op = 3'b011;
         2'b10:   exp_sh_op = 3'b100;
         default: exp_sh_op = 3'b000;
      endcase

      lat = 0;
      while (!bus.cmd_ready && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("cmd_ready_wait", 32'(bus.cmd_ready), 1);

      load0  = n_load;
      shift0 = n_shift;
      bad0   = n_badop;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_shamt = sh;
      bus.cmd_rep   = rep;
      bus.cmd_data  = data;
      @(posedge clk); #1;
      // Scramble the command inputs: they must be ignored once latched.
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'($urandom);
      bus.cmd_shamt = 2'($urandom);
      bus.cmd_rep   = 4'($urandom);
      bus.cmd_data  = 8'($urandom);
      check("busy_ready", 32'(bus.cmd_ready), 0);

      lat = 0;
      while (!bus.res_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, eff + 2);
      check("res_data", 32'(bus.res_data), 32'(exp));
      check("res_err", 32'(bus.res_err), 0);
      check("load_cnt", n_load - load0, 1);
      check("shift_cnt", n_shift - shift0, eff);
      check("bad_op", n_badop - bad0, 0);

      held = bus.res_data;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("bp_valid", 32'(bus.res_valid), 1);
         check("bp_data", 32'(bus.res_data), 32'(held));
         check("bp_ready", 32'(bus.cmd_ready), 0);
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      bus.cmd_valid = 1'b0;
      check("post_valid", 32'(bus.res_valid), 0);
      check("post_ready", 32'(bus.cmd_ready), 1);
      $display("cmd op=%0d shamt=%0d rep=%0d data=0x%02h -> res=0x%02h exp=0x%02h lat=%0d hold=%0d",
               op, sh, rep, data, held, exp, lat, hold);
   endtask

   initial begin
      int seen;
      n_checks      = 0;
      n_fail        = 0;
      exp_sh_op     = 3'b000;
      reset_n       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_shamt = '0;
      bus.cmd_rep   = '0;
      bus.cmd_data  = '0;
      bus.res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
      check("rst_sh_op", 32'(sh_op), 0);
      check("rst_res_valid", 32'(bus.res_valid), 0);
      check("rst_res_data", 32'(bus.res_data), 0);
      check("rst_res_err", 32'(bus.res_err), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_cmd(2'b00, 2'd1, 4'd1, 8'h77, 0);
      run_cmd(2'b01, 2'd3, 4'd2, 8'h87, 0);
      run_cmd(2'b10, 2'd1, 4'd3, 8'h87, 0);
      run_cmd(2'b00, 2'd2, 4'd0, 8'h55, 0);
      run_cmd(2'b11, 2'd1, 4'd5, 8'hA5, 0);
      run_cmd(2'b10, 2'd0, 4'd4, 8'h9C, 0);
      run_cmd(2'b01, 2'd2, 4'd15, 8'hFF, 5);

      // Reset in the middle of a long SHIFT phase.
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b00;
      bus.cmd_shamt = 2'd1;
      bus.cmd_rep   = 4'd8;
      bus.cmd_data  = 8'h3C;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      check("mid_in_shift", 32'(sh_op), 32'(3'b010));
      reset_n = 1'b0;
      #1;
      check("mid_cmd_ready", 32'(bus.cmd_ready), 1);
      check("mid_sh_op", 32'(sh_op), 0);
      check("mid_sh_shamt", 32'(sh_shamt), 0);
      check("mid_sh_d_in", 32'(sh_d_in), 0);
      check("mid_res_valid", 32'(bus.res_valid), 0);
      check("mid_res_data", 32'(bus.res_data), 0);
      check("mid_res_err", 32'(bus.res_err), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.res_valid) seen++;
      end
      check("abort_no_result", seen, 0);
      check("abort_ready", 32'(bus.cmd_ready), 1);
      $display("reset mid-op: result discarded, cmd_ready=%0d", bus.cmd_ready);

      for (int k = 0; k < 40; k++) begin
         run_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 8'($urandom), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Command sequencer that sits directly upstream of the 8-bit registered shifter (shifter8) and drives its op/shamt/d_in inputs.
- Accepts one shift command per valid/ready handshake and issues LOAD, then a programmable number of shift steps.
- Captures the shifter output and returns it on a result handshake with backpressure.

Parameters:
- DW, 8, data width; matches the shifter.
- REP_W, 4, width of the repeat count, so up to 15 shift steps per command.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 LSL, 01 LSR, 10 ASR, 11 reserved
- cmd_shamt  in  2  shift amount per step, 0..3
- cmd_rep  in  REP_W  number of shift steps (0 = load only)
- cmd_data  in  DW  operand
- sh_op  out  3  to shifter op: 000 NOP, 001 LOAD, 010 LSL, 011 LSR, 100 ASR
- sh_shamt  out  2  to shifter shamt
- sh_d_in  out  DW  to shifter d_in
- sh_q  in  DW  from shifter d_out (registered in the shifter)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_data  out  DW  captured result
- res_err  out  1  model mismatch flag (optional feature only)

Behaviour:
- Reset (async, any state): state=IDLE, cmd_ready=1, sh_op=000, sh_shamt=0, sh_d_in=0, res_valid=0, res_data=0, res_err=0, rep counter=0.
- All sh_* outputs and res_* outputs are registered.
- States: IDLE, LOAD, SHIFT, CAPT, RESP.
- IDLE:
  - cmd_ready=1; sh_op=NOP.
  - On cmd_valid&&cmd_ready, latch op, shamt, rep and data, then go to LOAD.
  - cmd_ready is low in every other state.
- LOAD (1 cycle): sh_op=001, sh_d_in=latched data. Next state is SHIFT if rep!=0, else CAPT.
- SHIFT (exactly rep cycles):
  - sh_op = 010, 011 or 100 for latched op 00, 01 or 10; sh_shamt=latched shamt.
  - Counter decrements each cycle; go to CAPT after the cycle in which counter==1.
- CAPT (1 cycle): sh_op=NOP; res_data<=sh_q at the end of the cycle; go to RESP.
- RESP:
  - res_valid=1; res_data is held stable.
  - Leave for IDLE on res_ready. res_valid drops on the following edge.
- Latency: from the acceptance edge, res_valid rises after rep+2 cycles (LOAD + rep SHIFT + CAPT).
- Reserved cmd_op=11: the command is accepted and forced to load-only (rep treated as 0). The result equals cmd_data.
- sh_shamt=0 with a shift op is legal; the shifter output is unchanged.
- No back-to-back overlap: a result handshake and a new command cannot complete in the same cycle. The next command is accepted no earlier than the cycle after leaving RESP.
- cmd_* inputs are ignored outside IDLE; changes have no effect after the command is latched.
- Reset asserted mid-sequence aborts immediately: outputs go to reset values and the pending result is discarded.
- The shifter is treated as single-cycle registered: the op applied in cycle k is visible on sh_q in cycle k+1.

Optional Feature:
- Macro: SHIFT_SEQ_CHK_EN.
- Defined:
  - An internal reference register is loaded with data at LOAD and updated each SHIFT cycle by the same operation. ASR replicates the MSB; LSR/LSL zero-fill.
  - In CAPT, res_err<=(sh_q!=model). res_err is valid with res_valid and cleared on leaving RESP.
- Undefined: no model register; res_err is tied to 0.

Decomposition:
- Package shift_pkg holds the shared encodings:
  - 3-bit shifter op constants (OP_NOP, OP_LOAD, OP_LSL, OP_LSR, OP_ASR).
  - 2-bit command op constants.
  - State enum.
- A function in the package maps command op to shifter op.
- One natural sub-module: shift_seq_model, the checking reference register, instantiated only under SHIFT_SEQ_CHK_EN.
- The bench connects shift_seq to shifter8.

Test Plan:
- LSL: cmd_op=00, shamt=1, rep=1, data=0x77 -> res_data=0xEE, res_valid 3 cycles after accept.
- LSR: cmd_op=01, shamt=3, rep=2, data=0x87 -> res_data=0x02 after 4 cycles.
- ASR: cmd_op=10, shamt=1, rep=3, data=0x87 -> sh_q sequence 0xC3, 0xE1, 0xF0; res_data=0xF0; res_err=0 with SHIFT_SEQ_CHK_EN.
- Load only: rep=0 data=0x55, then cmd_op=11 rep=5 data=0xA5 -> res_data=0x55 then 0xA5, each 2 cycles after accept, no shift ops on sh_op.
- Backpressure: res_ready held low 5 cycles with cmd_valid high -> res_valid/res_data stable and cmd_ready=0 throughout; next command accepted only after the res_ready handshake.
- Reset mid-op: assert reset_n=0 during SHIFT of rep=8 -> outputs to reset values asynchronously, cmd_ready=1 after release, no res_valid for the aborted command.
